// File: rtl/kbd_pkg.sv
// Shared constants for the memory-mapped keyboard controller: register
// indices, status bit positions and the bus-response FSM encoding.
package kbd_pkg;

  localparam logic [1:0] KBD_IDX_STAT = 2'd0;
  localparam logic [1:0] KBD_IDX_KEY  = 2'd1;

  localparam int KBD_STAT_NEMPTY = 0;
  localparam int KBD_STAT_FULL   = 1;
  localparam int KBD_STAT_OVF    = 2;
  localparam int KBD_STAT_IRQEN  = 3;
  localparam int KBD_STAT_CNT    = 8;

  typedef enum logic {
    KBD_IDLE = 1'b0,
    KBD_RESP = 1'b1
  } kbd_state_t;

endpackage

// File: rtl/kbd_fifo.sv
// Scan-code FIFO: natural-wrap pointers plus an occupancy count. A push into a
// full FIFO is dropped, with fullness judged before any same-edge pop.
module kbd_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 5,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/kbd_ctrl.sv
// Keyboard controller bus responder: decodes the 16-byte window, serves status
// reads and key pops through a two-state IDLE/RESP handshake, drives a level irq.
module kbd_ctrl
  import kbd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hC000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_strobe,
  input  logic [7:0]  key_code,
  input  logic        bus_req,
  input  logic        bus_wr,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        kbd_irq
);

  kbd_state_t       state;
  kbd_state_t       state_nxt;
  logic             hit;
  logic [1:0]       idx;
  logic             pop;
  logic             stat_wr;
  logic [31:0]      rdata_nxt;
  logic [31:0]      rdata_p1;
  logic             ovf;
  logic             irq_en;
  logic             irq_q;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_bits;

  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:4], bus_wdata[1:0]};

  function automatic logic [31:0] pack_stat(input logic nempty, input logic full,
                                            input logic ovf_b, input logic irq_en_b,
                                            input logic [CNT_W-1:0] cnt);
    logic [31:0] s;
    s = '0;
    s[KBD_STAT_NEMPTY]        = nempty;
    s[KBD_STAT_FULL]          = full;
    s[KBD_STAT_OVF]           = ovf_b;
    s[KBD_STAT_IRQEN]         = irq_en_b;
    s[KBD_STAT_CNT +: CNT_W]  = cnt;
    return s;
  endfunction

  kbd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W),
    .DATA_W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (key_strobe),
    .pop   (pop),
    .din   (key_code),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign hit = bus_req && (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign idx = bus_addr[3:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= KBD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rdata_nxt = '0;
    pop       = 1'b0;
    stat_wr   = 1'b0;
    case (state)
      KBD_IDLE: begin
        if (hit) begin
          state_nxt = KBD_RESP;
          if (bus_wr) begin
            stat_wr = (idx == KBD_IDX_STAT);
          end else if (idx == KBD_IDX_STAT) begin
            rdata_nxt = pack_stat(!fifo_empty, fifo_full, ovf, irq_en, fifo_count);
          end else if (idx == KBD_IDX_KEY) begin
            // An empty FIFO answers 0; a same-edge push is not bypassed.
            rdata_nxt = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
            pop       = !fifo_empty;
          end
        end
      end
      KBD_RESP: begin
        state_nxt = KBD_IDLE;
      end
      default: begin
        state_nxt = KBD_IDLE;
      end
    endcase
  end

  // Response stage: read data captured when the request is accepted.
  always_ff @(posedge clk) begin
    if (state == KBD_IDLE && hit) begin
      rdata_p1 <= rdata_nxt;
    end
  end

  // Overflow set outranks a same-edge software clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf    <= 1'b0;
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ovf   <= (ovf && !(stat_wr && bus_wdata[KBD_STAT_OVF])) || (key_strobe && fifo_full);
      irq_q <= irq_en && (fifo_count != '0);
      if (stat_wr) begin
        irq_en <= bus_wdata[KBD_STAT_IRQEN];
      end
    end
  end

  assign bus_ack   = (state == KBD_RESP);
  assign bus_rdata = bus_ack ? rdata_p1 : 32'd0;
  assign kbd_irq   = irq_q;

endmodule

// File: tb/tb_kbd_ctrl.sv
// Directed bench for kbd_ctrl: bus reads/writes with hand-computed expectations.
module tb_kbd_ctrl;

  localparam logic [31:0] BASE = 32'hC000_0000;
  localparam logic [31:0] KEY  = 32'hC000_0004;

  logic        clk;
  logic        rst;
  logic        key_strobe;
  logic [7:0]  key_code;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        kbd_irq;
  logic        irq_at_ack;

  int n_chk;
  int n_err;

  kbd_ctrl #(
    .BASE_ADDR  (32'hC000_0000),
    .FIFO_DEPTH (4),
    .CNT_W      (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .bus_req    (bus_req),
    .bus_wr     (bus_wr),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .kbd_irq    (kbd_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts anywhere after an edge, ends #1 after an edge. lat = 0 means no ack.
  task automatic bus_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic stb, input logic [7:0] code,
                          output logic [31:0] rdata, output int lat);
    bus_wr     = wr;
    bus_addr   = addr;
    bus_wdata  = wdata;
    bus_req    = 1'b1;
    key_strobe = stb;
    key_code   = code;
    lat        = 0;
    rdata      = '0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      key_strobe = 1'b0;
      if (bus_ack) begin
        lat        = i;
        rdata      = bus_rdata;
        irq_at_ack = kbd_irq;
        break;
      end
    end
    bus_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                        input logic stb = 1'b0, input logic [7:0] code = 8'h00);
    logic [31:0] r;
    int          lat;
    bus_xfer(1'b0, addr, 32'd0, stb, code, r, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk(tag, r, exp);
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] r;
    int          lat;
    bus_xfer(1'b1, addr, wdata, 1'b0, 8'h00, r, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic strobe(input logic [7:0] code);
    key_strobe = 1'b1;
    key_code   = code;
    @(posedge clk);
    #1;
    key_strobe = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int          lat;
    n_chk      = 0;
    n_err      = 0;
    rst        = 1'b1;
    key_strobe = 1'b0;
    key_code   = '0;
    bus_req    = 1'b0;
    bus_wr     = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    irq_at_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus_ack), 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_irq", 32'(kbd_irq), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    rd_chk("stat_reset", BASE, 32'h0000_0000);
    chk("irq_reset", 32'(kbd_irq), 32'd0);

    strobe(8'h1C);
    strobe(8'h32);
    rd_chk("stat_two", BASE, 32'h0000_0201);
    rd_chk("key_1c", KEY, 32'h0000_001C);
    rd_chk("key_32", KEY, 32'h0000_0032);
    rd_chk("stat_drained", BASE, 32'h0000_0000);

    for (int i = 0; i < 5; i++) strobe(8'h10 + 8'(i));
    rd_chk("stat_ovf", BASE, 32'h0000_0407);
    for (int i = 0; i < 4; i++) rd_chk("key_ovf_seq", KEY, 32'h10 + 32'(i));
    wr_chk("wr_clr_ovf", BASE, 32'h4);
    rd_chk("stat_ovf_clr", BASE, 32'h0000_0000);

    wr_chk("wr_irq_en", BASE, 32'h8);
    strobe(8'h5A);
    chk("irq_push_edge", 32'(kbd_irq), 32'd0);
    @(posedge clk);
    #1;
    chk("irq_rise", 32'(kbd_irq), 32'd1);
    rd_chk("stat_irq", BASE, 32'h0000_0109);
    rd_chk("key_5a", KEY, 32'h0000_005A);
    chk("irq_at_pop_ack", 32'(irq_at_ack), 32'd1);
    chk("irq_fall", 32'(kbd_irq), 32'd0);
    wr_chk("wr_irq_dis", BASE, 32'h0);

    strobe(8'hA1);
    strobe(8'hA2);
    rd_chk("key_pp2", KEY, 32'h0000_00A1, 1'b1, 8'hA3);
    rd_chk("stat_pp2", BASE, 32'h0000_0201);
    rd_chk("key_pp2_a2", KEY, 32'h0000_00A2);
    rd_chk("key_pp2_a3", KEY, 32'h0000_00A3);

    rd_chk("key_pp0", KEY, 32'h0000_0000, 1'b1, 8'hB1);
    rd_chk("stat_pp0", BASE, 32'h0000_0101);
    rd_chk("key_pp0_b1", KEY, 32'h0000_00B1);

    for (int i = 0; i < 4; i++) strobe(8'hC1 + 8'(i));
    rd_chk("key_pp4", KEY, 32'h0000_00C1, 1'b1, 8'hC5);
    rd_chk("stat_pp4", BASE, 32'h0000_0305);
    rd_chk("key_pp4_c2", KEY, 32'h0000_00C2);
    rd_chk("key_pp4_c3", KEY, 32'h0000_00C3);
    rd_chk("key_pp4_c4", KEY, 32'h0000_00C4);
    rd_chk("key_pp4_empty", KEY, 32'h0000_0000);
    wr_chk("wr_clr_ovf2", BASE, 32'h4);
    rd_chk("stat_pp4_clr", BASE, 32'h0000_0000);

    rd_chk("idx2", 32'hC000_0008, 32'h0000_0000);
    bus_xfer(1'b0, 32'hB000_0000, 32'd0, 1'b0, 8'h00, r, lat);
    chk("miss_no_ack", 32'(lat), 32'd0);

    strobe(8'hD1);
    strobe(8'hD2);
    bus_wr   = 1'b0;
    bus_addr = BASE;
    bus_req  = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_pre_ack", 32'(bus_ack), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ack", 32'(bus_ack), 32'd0);
    chk("rst_mid_rdata", bus_rdata, 32'd0);
    bus_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rd_chk("stat_after_rst", BASE, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
